// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
//
// Accepts a framed byte stream over valid/ready:
//   SYNC_BYTE, CNT_HI, CNT_LO, N*4 data bytes (big-endian words), CSUM
// CSUM is the XOR of every byte after SYNC_BYTE.
// Assembled words are written to imem from word 0 upward. The CPU is held
// (o_cpu_run=0) until a complete frame with a matching checksum has loaded.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_restart      synchronous pulse: abort, return to idle, drop cpu_run
//   i_in_valid     byte available on i_in_data
//   i_in_data      stream byte
//   o_in_ready     byte accepted this cycle when i_in_valid is also high
//   o_imem_we      one-cycle instruction-memory write strobe
//   o_imem_addr    word address of the write
//   o_imem_wdata   instruction word to write
//   o_words_loaded words written in the current frame
//   o_cpu_run      1 = CPU may leave reset
//   o_load_err     sticky error (bad count or bad checksum) until restart
module imem_loader #(
  parameter int unsigned ADDR_W    = 7,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_restart,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [ADDR_W:0]   o_words_loaded,
  output logic              o_cpu_run,
  output logic              o_load_err
);

  // Memory depth as a 17-bit value so that a 16-bit count can be compared
  // against it even when the depth itself needs bit 16.
  localparam logic [16:0]   DepthW  = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] WidxOne = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StData,
    StCsum,
    StRun,
    StErr
  } state_e;

  state_e            r_state,  w_state_d;
  logic [15:0]       r_cnt,    w_cnt_d;
  logic [7:0]        r_csum,   w_csum_d;
  logic [1:0]        r_bidx,   w_bidx_d;
  logic [23:0]       r_asm,    w_asm_d;
  logic [ADDR_W:0]   r_widx,   w_widx_d;
  logic              r_we,     w_we_d;
  logic [ADDR_W-1:0] r_addr,   w_addr_d;
  logic [31:0]       r_wdata,  w_wdata_d;

  logic              w_hs;
  logic [15:0]       w_cnt_full;
  logic [ADDR_W:0]   w_widx_inc;

  // restart forces ready low so a byte offered alongside it is never consumed.
  assign o_in_ready = !i_restart && (r_state != StRun);
  assign w_hs       = i_in_valid && o_in_ready;
  assign w_cnt_full = {r_cnt[15:8], i_in_data};
  assign w_widx_inc = r_widx + WidxOne;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_csum_d  = r_csum;
    w_bidx_d  = r_bidx;
    w_asm_d   = r_asm;
    w_widx_d  = r_widx;
    w_we_d    = 1'b0;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;

    if (i_restart) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_csum_d  = '0;
      w_bidx_d  = '0;
      w_asm_d   = '0;
      w_widx_d  = '0;
    end else if (w_hs) begin
      unique case (r_state)
        StIdle: begin
          // Non-sync bytes are consumed and dropped.
          if (i_in_data == SYNC_BYTE) begin
            w_state_d = StCntHi;
            w_csum_d  = '0;
            w_bidx_d  = '0;
            w_widx_d  = '0;
          end
        end
        StCntHi: begin
          w_cnt_d[15:8] = i_in_data;
          w_csum_d      = r_csum ^ i_in_data;
          w_state_d     = StCntLo;
        end
        StCntLo: begin
          w_cnt_d  = w_cnt_full;
          w_csum_d = r_csum ^ i_in_data;
          if ({1'b0, w_cnt_full} > DepthW) begin
            w_state_d = StErr;
          end else if (w_cnt_full == 16'd0) begin
            w_state_d = StCsum;
          end else begin
            w_state_d = StData;
          end
        end
        StData: begin
          w_csum_d = r_csum ^ i_in_data;
          if (r_bidx == 2'd3) begin
            // Word complete: strobe appears on the outputs next cycle.
            w_we_d    = 1'b1;
            w_addr_d  = r_widx[ADDR_W-1:0];
            w_wdata_d = {r_asm, i_in_data};
            w_widx_d  = w_widx_inc;
            w_bidx_d  = 2'd0;
            if (16'(w_widx_inc) == r_cnt) begin
              w_state_d = StCsum;
            end
          end else begin
            w_asm_d  = {r_asm[15:0], i_in_data};
            w_bidx_d = r_bidx + 2'd1;
          end
        end
        StCsum: begin
          w_state_d = (i_in_data == r_csum) ? StRun : StErr;
        end
        default: begin
          // StErr drains bytes; StRun never handshakes.
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_bidx  <= '0;
      r_asm   <= '0;
      r_widx  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_csum  <= w_csum_d;
      r_bidx  <= w_bidx_d;
      r_asm   <= w_asm_d;
      r_widx  <= w_widx_d;
      r_we    <= w_we_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
    end
  end

  assign o_imem_we      = r_we;
  assign o_imem_addr    = r_addr;
  assign o_imem_wdata   = r_wdata;
  assign o_words_loaded = r_widx;
  assign o_cpu_run      = (r_state == StRun);
  assign o_load_err     = (r_state == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames plus randomized frames checked
// against a frame-level reference model (expected words, checksum, outcome).
module tb_imem_loader;

  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;
  logic          cpu_run;
  logic          load_err;

  imem_loader #(
    .ADDR_W    (AW),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_restart      (restart),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .o_in_ready     (in_ready),
    .o_imem_we      (imem_we),
    .o_imem_addr    (imem_addr),
    .o_imem_wdata   (imem_wdata),
    .o_words_loaded (words_loaded),
    .o_cpu_run      (cpu_run),
    .o_load_err     (load_err)
  );

  always #5 clk = ~clk;

  // Instruction memory as seen through the write port.
  logic [31:0] cap_mem [DEPTH];
  int          we_total  = 0;
  int          last_addr = -1;

  always @(negedge clk) begin
    if (imem_we) begin
      cap_mem[imem_addr] = imem_wdata;
      we_total++;
      last_addr = int'(imem_addr);
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_words [DEPTH];
  logic [7:0]  frame_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL hs_timeout observed=ready_low expected=ready_high byte=%0h", b);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame_q(input int max_gap);
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], max_gap);
  endtask

  // Reference frame builder: checksum is XOR of all bytes after sync.
  task automatic build_frame(input int n, input bit good);
    logic [7:0] cs;
    logic [7:0] bt;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n & 255));
    cs = 8'(n >> 8) ^ 8'(n & 255);
    for (int w = 0; w < n; w++) begin
      for (int k = 3; k >= 0; k--) begin
        bt = 8'((ref_words[w] >> (8 * k)) & 32'hFF);
        frame_q.push_back(bt);
        cs = cs ^ bt;
      end
    end
    if (!good) cs = cs ^ 8'($urandom_range(1, 255));
    frame_q.push_back(cs);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    bit good;

    // Reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: good two-word frame
    base = we_total;
    ref_words[0] = 32'h8C030000;
    ref_words[1] = 32'h00000020;
    build_frame(2, 1'b1);
    chk("t1_csum_byte", 32'(frame_q[frame_q.size()-1]), 32'hAD);
    send_frame_q(0);
    chk("t1_cpu_run", 32'(cpu_run), 32'd1);
    chk("t1_load_err", 32'(load_err), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    chk("t1_mem0", cap_mem[0], 32'h8C030000);
    chk("t1_mem1", cap_mem[1], 32'h00000020);
    chk("t1_words", 32'(words_loaded), 32'd2);
    chk("t1_we_cnt", 32'(we_total - base), 32'd2);
    do_restart();
    chk("t1_rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("t1_rst_words", 32'(words_loaded), 32'd0);

    // 2: same frame, bad checksum 0x00
    base = we_total;
    cap_mem[0] = 32'h0;
    cap_mem[1] = 32'h0;
    frame_q[frame_q.size()-1] = 8'h00;
    send_frame_q(1);
    chk("t2_load_err", 32'(load_err), 32'd1);
    chk("t2_cpu_run", 32'(cpu_run), 32'd0);
    chk("t2_in_ready", 32'(in_ready), 32'd1);
    chk("t2_mem0", cap_mem[0], 32'h8C030000);
    chk("t2_mem1", cap_mem[1], 32'h00000020);
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    chk("t2_drain_err", 32'(load_err), 32'd1);
    chk("t2_drain_we", 32'(we_total - base), 32'd2);
    do_restart();
    chk("t2_rst_err", 32'(load_err), 32'd0);

    // 3: count too large
    base = we_total;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h81, 0);
    repeat (3) tick();
    chk("t3_load_err", 32'(load_err), 32'd1);
    chk("t3_we_cnt", 32'(we_total - base), 32'd0);
    chk("t3_cpu_run", 32'(cpu_run), 32'd0);
    do_restart();

    // 4: garbage then empty frame
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t4_cpu_run", 32'(cpu_run), 32'd1);
    chk("t4_words", 32'(words_loaded), 32'd0);
    chk("t4_load_err", 32'(load_err), 32'd0);
    do_restart();

    // 5: restart collides with a data byte mid-word
    base = we_total;
    ref_words[0] = 32'h01020304;
    ref_words[1] = 32'h05060708;
    build_frame(2, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(frame_q[i], 0);
    in_valid = 1'b1;
    in_data  = 8'h07;
    restart  = 1'b1;
    #1;
    chk("t5_ready_low", 32'(in_ready), 32'd0);
    tick();
    restart  = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    chk("t5_load_err", 32'(load_err), 32'd0);
    chk("t5_cpu_run", 32'(cpu_run), 32'd0);
    chk("t5_words", 32'(words_loaded), 32'd0);
    chk("t5_we_cnt", 32'(we_total - base), 32'd1);
    // A fresh frame must start on a clean byte index.
    ref_words[0] = 32'hDEADBEEF;
    build_frame(1, 1'b1);
    send_frame_q(0);
    chk("t5_fresh_mem0", cap_mem[0], 32'hDEADBEEF);
    chk("t5_fresh_run", 32'(cpu_run), 32'd1);
    do_restart();

    // 6: full-depth frame with random gaps
    base = we_total;
    for (int w = 0; w < DEPTH; w++) ref_words[w] = $urandom;
    build_frame(DEPTH, 1'b1);
    send_frame_q(3);
    chk("t6_cpu_run", 32'(cpu_run), 32'd1);
    chk("t6_we_cnt", 32'(we_total - base), 32'(DEPTH));
    chk("t6_last_addr", 32'(last_addr), 32'(DEPTH - 1));
    chk("t6_words", 32'(words_loaded), 32'(DEPTH));
    for (int w = 0; w < DEPTH; w++) chk($sformatf("t6_mem%0d", w), cap_mem[w], ref_words[w]);
    do_restart();

    // Random short frames, good or corrupted checksum
    for (int it = 0; it < 4; it++) begin
      base = we_total;
      n    = int'($urandom_range(1, 12));
      good = 1'($urandom_range(0, 1));
      for (int w = 0; w < n; w++) ref_words[w] = $urandom;
      build_frame(n, good);
      send_frame_q(2);
      chk($sformatf("r%0d_cpu_run", it), 32'(cpu_run), 32'(good));
      chk($sformatf("r%0d_load_err", it), 32'(load_err), 32'(!good));
      chk($sformatf("r%0d_words", it), 32'(words_loaded), 32'(n));
      chk($sformatf("r%0d_we_cnt", it), 32'(we_total - base), 32'(n));
      for (int w = 0; w < n; w++) chk($sformatf("r%0d_mem%0d", it, w), cap_mem[w], ref_words[w]);
      do_restart();
    end

    // Async reset mid-frame
    ref_words[0] = 32'hCAFEF00D;
    ref_words[1] = 32'h12345678;
    build_frame(2, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(frame_q[i], 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_words", 32'(words_loaded), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_imem_we", 32'(imem_we), 32'd0);
    chk("ar_mem0_kept", cap_mem[0], 32'hCAFEF00D);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame_q(1);
    chk("ar_cpu_run", 32'(cpu_run), 32'd1);
    chk("ar_mem1", cap_mem[1], 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
